axil_decoder_1to2: RTL
======================

# axil_decoder_1to2

Registered AXI4-Lite 1-master-to-2-slave decoder sitting between the picorv32_axi CPU and its slaves (port 0: SRAM wrapper, port 1: AES wrapper). It replaces purely combinational select/response muxing with per-transaction latching, so response routing never depends on the master's address staying stable. Unmapped accesses get a DECERR response, and the read and write paths run as independent state machines.

## Interface
Parameters:
- M0_BASE, 32'h0000_0000, port 0 window base
- M0_SIZE, 32'h0000_0200, port 0 window size in bytes
- M1_BASE, 32'h0000_0300, port 1 window base
- M1_SIZE, 32'h0000_0100, port 1 window size in bytes
- TIMEOUT, 255, slave-response watchdog limit in cycles (used only with AXIL_DEC_TIMEOUT_EN)

Ports:
- aclk  in  1  clock; single clock domain
- aresetn  in  1  reset; asynchronous assert, active-low
- s_awvalid/s_awready/s_awaddr  in/out/in  1/1/32  upstream write address
- s_wvalid/s_wready/s_wdata/s_wstrb  in/out/in/in  1/1/32/4  upstream write data
- s_bvalid/s_bready/s_bresp  out/in/out  1/1/2  upstream write response
- s_arvalid/s_arready/s_araddr  in/out/in  1/1/32  upstream read address
- s_rvalid/s_rready/s_rdata/s_rresp  out/in/out/out  1/1/32/2  upstream read data
- mN_awvalid/mN_awready/mN_awaddr, N=0,1  out/in/out  1/1/32  downstream write address
- mN_wvalid/mN_wready/mN_wdata/mN_wstrb  out/in/out/out  1/1/32/4  downstream write data
- mN_bvalid/mN_bready/mN_bresp  in/out/in  1/1/2  downstream write response
- mN_arvalid/mN_arready/mN_araddr  out/in/out  1/1/32  downstream read address
- mN_rvalid/mN_rready/mN_rdata/mN_rresp  in/out/in/in  1/1/32/2  downstream read data

## Operation
- Decode: hit on port N when BASE_N <= addr < BASE_N+SIZE_N, using 33-bit compare so there is no wrap. If the windows overlap, port 0 wins. No hit means DECERR.
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_ERR.
  - W_IDLE: s_awready = s_wready = s_awvalid & s_wvalid, so AW and W are always accepted together. On accept, latch addr, data, strb and port select. Go to W_FWD on a hit, W_ERR on a miss.
  - W_FWD: drive the selected mN_awvalid/mN_wvalid from the latched values. Each drops independently after its own ready handshake. Go to W_RESP when both are done.
  - W_RESP: mN_bready = !s_bvalid. On the mN_bvalid handshake, register bresp and set s_bvalid. On the s_bvalid & s_bready handshake, go to W_IDLE.
  - W_ERR: s_bvalid=1, s_bresp=2'b11 until s_bready, then W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_ERR.
  - R_IDLE: s_arready=1; latch addr and port select on the handshake.
  - R_FWD: mN_arvalid held until mN_arready.
  - R_RESP: mN_rready = !s_rvalid. Register rdata/rresp, present on s_r*, clear on s_rready.
  - R_ERR: s_rvalid=1, s_rresp=2'b11, s_rdata=0.
- Unselected port outputs are held at 0. Address/data outputs show the latched values.
- Read and write may be in flight at the same time, including to the same port.

## Timing
- Reset: all valid/ready outputs 0, except s_arready=1 (R_IDLE). s_bresp/s_rresp/s_rdata = 0. Both FSMs go to IDLE. Assertion mid-transaction aborts immediately; no response is produced.
- Write latency, zero-wait slave: accept at cycle 0, mN_aw/w valid at cycle 1, mN_bvalid at cycle 2 earliest, s_bvalid at cycle 3.
- Read latency: accept at cycle 0, mN_arvalid at cycle 1, s_rvalid one cycle after the mN_rvalid handshake.
- Throughput: one outstanding transaction per direction. The next accept comes no earlier than the cycle after the upstream response handshake.
- AXI rules: a valid is never dropped before its ready. Payload is stable while valid is high. No combinational path from any m*ready to any s*ready.

## Configuration
- AXIL_DEC_TIMEOUT_EN defined:
  - A per-direction counter runs in FWD/RESP states. It reloads on every downstream handshake.
  - When the counter reaches TIMEOUT, the FSM drops mN valids and returns SLVERR (2'b10) upstream, with s_rdata=0 for reads.
  - In IDLE, mN_bready/mN_rready are driven 1 on both ports so stray late responses are sunk and discarded.
- Undefined: no counter; the FSM waits indefinitely. In IDLE, mN_bready/mN_rready = 0.

## Test plan
- Write 0x0000_0010 with data 0xA5A5_5A5A, strb 4'hF → m0 sees the same addr/data/strb; s_bresp=OKAY; s_bvalid asserts 3 cycles after accept with a zero-wait slave.
- Read 0x0000_0304 with m1 returning 0x1234_5678 → s_rdata=0x1234_5678, s_rresp=OKAY; m0_arvalid never asserts.
- Write 0x0000_0250 and read 0x0000_1000 → both complete with resp=2'b11, rdata=0; no mN valid ever asserts.
- Concurrent write to m0 and read from m1, with m0_awready delayed 4 cycles and m1_rvalid delayed 2 cycles → both complete correctly and independently; s_bvalid held until s_bready.
- aresetn low during W_RESP while m0_bvalid=0 → all outputs at reset values, no s_bvalid produced; the next write completes normally.
- With AXIL_DEC_TIMEOUT_EN and TIMEOUT=8, m1 never asserts arready → s_rvalid with s_rresp=2'b10 exactly after the 8-cycle timeout; m1_arvalid deasserts.

Source files
------------

// File: rtl/axil_decoder_1to2.sv
// axil_decoder_1to2 -- registered AXI4-Lite 1-master / 2-slave decoder.
//
// Sits between the CPU master (s_*) and two slaves (m0_*: SRAM, m1_*: AES).
// Every transaction is latched on acceptance (address, data, strobe, port
// select), so response routing never depends on the master's bus staying
// stable. Addresses outside both windows are answered locally with DECERR.
// The read and write paths are independent FSMs with one transaction
// outstanding each.
//
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   s_aw*/s_w*/s_b*      upstream write address / data / response
//   s_ar*/s_r*           upstream read address / data
//   m0_*, m1_*           downstream AXI4-Lite ports (same channel set)
//
// Optional feature: define AXIL_DEC_TIMEOUT_EN to enable a per-direction
// watchdog (TIMEOUT cycles without a downstream handshake -> SLVERR) and to
// sink stray downstream responses while idle.
module axil_decoder_1to2 #(
   parameter logic [31:0] M0_BASE = 32'h0000_0000,
   parameter logic [31:0] M0_SIZE = 32'h0000_0200,
   parameter logic [31:0] M1_BASE = 32'h0000_0300,
   parameter logic [31:0] M1_SIZE = 32'h0000_0100,
   parameter int          TIMEOUT = 255
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_awvalid, output logic s_awready, input logic [31:0] s_awaddr,
   input  logic        s_wvalid,  output logic s_wready,  input logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   output logic        s_bvalid,  input  logic s_bready,  output logic [1:0] s_bresp,
   input  logic        s_arvalid, output logic s_arready, input logic [31:0] s_araddr,
   output logic        s_rvalid,  input  logic s_rready,  output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        m0_awvalid, input logic m0_awready, output logic [31:0] m0_awaddr,
   output logic        m0_wvalid,  input logic m0_wready,  output logic [31:0] m0_wdata,
   output logic [3:0]  m0_wstrb,
   input  logic        m0_bvalid,  output logic m0_bready, input logic [1:0] m0_bresp,
   output logic        m0_arvalid, input logic m0_arready, output logic [31:0] m0_araddr,
   input  logic        m0_rvalid,  output logic m0_rready, input logic [31:0] m0_rdata,
   input  logic [1:0]  m0_rresp,
   output logic        m1_awvalid, input logic m1_awready, output logic [31:0] m1_awaddr,
   output logic        m1_wvalid,  input logic m1_wready,  output logic [31:0] m1_wdata,
   output logic [3:0]  m1_wstrb,
   input  logic        m1_bvalid,  output logic m1_bready, input logic [1:0] m1_bresp,
   output logic        m1_arvalid, input logic m1_arready, output logic [31:0] m1_araddr,
   input  logic        m1_rvalid,  output logic m1_rready, input logic [31:0] m1_rdata,
   input  logic [1:0]  m1_rresp
);
   typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_st_t;
   typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_st_t;

   // One-hot port select; 2'b00 = no hit. 33-bit compare avoids wrap at 4 GiB.
   function automatic logic [1:0] decode(input logic [31:0] a);
      logic [32:0] x;
      x = {1'b0, a};
      decode = 2'b00;
      if (x >= {1'b0, M0_BASE} && x < ({1'b0, M0_BASE} + {1'b0, M0_SIZE}))
         decode = 2'b01;
      else if (x >= {1'b0, M1_BASE} && x < ({1'b0, M1_BASE} + {1'b0, M1_SIZE}))
         decode = 2'b10;
   endfunction

   // ---------------- write path ----------------
   w_st_t       w_st, w_nx;
   logic [31:0] w_addr, w_data;
   logic [3:0]  w_strb;
   logic [1:0]  w_sel, w_hit;
   logic        aw_pend, w_pend, bvalid_q;
   logic [1:0]  bresp_q;
   logic        w_acc, aw_hs, w_hs, b_hs, sb_hs, w_tmo;

   assign w_hit = decode(s_awaddr);
   assign w_acc = (w_st == W_IDLE) && s_awvalid && s_wvalid;
   assign aw_hs = (w_st == W_FWD) && aw_pend &&
                  ((w_sel[0] && m0_awready) || (w_sel[1] && m1_awready));
   assign w_hs  = (w_st == W_FWD) && w_pend &&
                  ((w_sel[0] && m0_wready) || (w_sel[1] && m1_wready));
   assign b_hs  = (w_st == W_RESP) && !bvalid_q &&
                  ((w_sel[0] && m0_bvalid) || (w_sel[1] && m1_bvalid));
   assign sb_hs = bvalid_q && s_bready;

   // ---------------- read path ----------------
   r_st_t       r_st, r_nx;
   logic [31:0] r_addr, rdata_q;
   logic [1:0]  r_sel, r_hit, rresp_q;
   logic        rvalid_q;
   logic        r_acc, ar_hs, rd_hs, sr_hs, r_tmo;

   assign r_hit = decode(s_araddr);
   assign r_acc = (r_st == R_IDLE) && s_arvalid;
   assign ar_hs = (r_st == R_FWD) &&
                  ((r_sel[0] && m0_arready) || (r_sel[1] && m1_arready));
   assign rd_hs = (r_st == R_RESP) && !rvalid_q &&
                  ((r_sel[0] && m0_rvalid) || (r_sel[1] && m1_rvalid));
   assign sr_hs = rvalid_q && s_rready;

`ifdef AXIL_DEC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] w_cnt, r_cnt;
   // Counter holds the number of waiting cycles already spent; the
   // TIMEOUT-th consecutive cycle without a downstream handshake fires.
   // A handshake in that same cycle wins over the timeout.
   assign w_tmo = (w_st == W_FWD || (w_st == W_RESP && !bvalid_q)) &&
                  !aw_hs && !w_hs && !b_hs && (w_cnt == TW'(TIMEOUT - 1));
   assign r_tmo = (r_st == R_FWD || (r_st == R_RESP && !rvalid_q)) &&
                  !ar_hs && !rd_hs && (r_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_cnt <= '0;
         r_cnt <= '0;
      end else begin
         if (w_acc || aw_hs || w_hs || b_hs) w_cnt <= '0;
         else if (w_st == W_FWD || w_st == W_RESP) w_cnt <= w_cnt + 1'b1;
         if (r_acc || ar_hs || rd_hs) r_cnt <= '0;
         else if (r_st == R_FWD || r_st == R_RESP) r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
   assign r_tmo = 1'b0;
`endif

   // State registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_st <= W_IDLE;
         r_st <= R_IDLE;
      end else begin
         w_st <= w_nx;
         r_st <= r_nx;
      end
   end

   // Next-state logic
   always_comb begin
      w_nx = w_st;
      case (w_st)
         W_IDLE: if (w_acc) w_nx = (|w_hit) ? W_FWD : W_ERR;
         W_FWD:  if (w_tmo) w_nx = W_ERR;
                 else if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) w_nx = W_RESP;
         W_RESP: if (w_tmo) w_nx = W_ERR;
                 else if (sb_hs) w_nx = W_IDLE;
         W_ERR:  if (sb_hs) w_nx = W_IDLE;
         default: w_nx = W_IDLE;
      endcase
   end

   always_comb begin
      r_nx = r_st;
      case (r_st)
         R_IDLE: if (r_acc) r_nx = (|r_hit) ? R_FWD : R_ERR;
         R_FWD:  if (r_tmo) r_nx = R_ERR;
                 else if (ar_hs) r_nx = R_RESP;
         R_RESP: if (r_tmo) r_nx = R_ERR;
                 else if (sr_hs) r_nx = R_IDLE;
         R_ERR:  if (sr_hs) r_nx = R_IDLE;
         default: r_nx = R_IDLE;
      endcase
   end

   // Latched transaction and registered upstream responses. Error and
   // timeout responses are loaded here too, so s_bvalid/s_rvalid are
   // always straight flop outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_addr <= '0; w_data <= '0; w_strb <= '0; w_sel <= '0;
         aw_pend <= 1'b0; w_pend <= 1'b0; bvalid_q <= 1'b0; bresp_q <= '0;
         r_addr <= '0; r_sel <= '0; rvalid_q <= 1'b0; rresp_q <= '0; rdata_q <= '0;
      end else begin
         if (w_acc) begin
            w_addr  <= s_awaddr;
            w_data  <= s_wdata;
            w_strb  <= s_wstrb;
            w_sel   <= w_hit;
            aw_pend <= |w_hit;
            w_pend  <= |w_hit;
            if (!(|w_hit)) begin
               bvalid_q <= 1'b1;
               bresp_q  <= 2'b11;
            end
         end
         if (aw_hs) aw_pend <= 1'b0;
         if (w_hs)  w_pend  <= 1'b0;
         if (b_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= w_sel[1] ? m1_bresp : m0_bresp;
         end
         if (w_tmo) begin
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= 2'b10;
         end
         if (sb_hs) begin
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
         end

         if (r_acc) begin
            r_addr <= s_araddr;
            r_sel  <= r_hit;
            if (!(|r_hit)) begin
               rvalid_q <= 1'b1;
               rresp_q  <= 2'b11;
               rdata_q  <= '0;
            end
         end
         if (rd_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= r_sel[1] ? m1_rresp : m0_rresp;
            rdata_q  <= r_sel[1] ? m1_rdata : m0_rdata;
         end
         if (r_tmo) begin
            rvalid_q <= 1'b1;
            rresp_q  <= 2'b10;
            rdata_q  <= '0;
         end
         if (sr_hs) begin
            rvalid_q <= 1'b0;
            rresp_q  <= '0;
            rdata_q  <= '0;
         end
      end
   end

   // Handshake outputs: functions of state and latched flags only, so no
   // m*ready reaches any s*ready combinationally.
   always_comb begin
      s_awready = 1'b0; s_wready = 1'b0;
      m0_awvalid = 1'b0; m1_awvalid = 1'b0; m0_wvalid = 1'b0; m1_wvalid = 1'b0;
      m0_bready = 1'b0; m1_bready = 1'b0;
      case (w_st)
         W_IDLE: begin
            s_awready = s_awvalid & s_wvalid;
            s_wready  = s_awvalid & s_wvalid;
`ifdef AXIL_DEC_TIMEOUT_EN
            m0_bready = 1'b1;
            m1_bready = 1'b1;
`endif
         end
         W_FWD: begin
            m0_awvalid = aw_pend & w_sel[0];
            m1_awvalid = aw_pend & w_sel[1];
            m0_wvalid  = w_pend & w_sel[0];
            m1_wvalid  = w_pend & w_sel[1];
         end
         W_RESP: begin
            m0_bready = w_sel[0] & ~bvalid_q;
            m1_bready = w_sel[1] & ~bvalid_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      s_arready = 1'b0;
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
      case (r_st)
         R_IDLE: begin
            s_arready = 1'b1;
`ifdef AXIL_DEC_TIMEOUT_EN
            m0_rready = 1'b1;
            m1_rready = 1'b1;
`endif
         end
         R_FWD: begin
            m0_arvalid = r_sel[0];
            m1_arvalid = r_sel[1];
         end
         R_RESP: begin
            m0_rready = r_sel[0] & ~rvalid_q;
            m1_rready = r_sel[1] & ~rvalid_q;
         end
         default: ;
      endcase
   end

   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_rvalid  = rvalid_q;
   assign s_rresp   = rresp_q;
   assign s_rdata   = rdata_q;

   // Payload shows the latched values on the selected port only.
   assign m0_awaddr = w_sel[0] ? w_addr : '0;
   assign m1_awaddr = w_sel[1] ? w_addr : '0;
   assign m0_wdata  = w_sel[0] ? w_data : '0;
   assign m1_wdata  = w_sel[1] ? w_data : '0;
   assign m0_wstrb  = w_sel[0] ? w_strb : '0;
   assign m1_wstrb  = w_sel[1] ? w_strb : '0;
   assign m0_araddr = r_sel[0] ? r_addr : '0;
   assign m1_araddr = r_sel[1] ? r_addr : '0;

endmodule
